// File: rtl/omsp_dadd_seq.sv
// Sequential BCD adder controller: walks the operands one nibble per cycle
// through an external nibble BCD adder and assembles the result and flags.
module omsp_dadd_seq (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        byte_mode,
    input  logic [15:0] op_src,
    input  logic [15:0] op_dst,
    input  logic        carry_in,
    output logic [3:0]  nib_a,
    output logic [3:0]  nib_b,
    output logic        nib_ci,
    input  logic [3:0]  nib_sum,
    input  logic        nib_co,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        flag_c,
    output logic        flag_z,
    output logic        flag_n
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic        byte_q;
    logic        carry_q;
    logic [1:0]  idx;
    logic [3:0]  bit_base;
    logic        last_nib;
    logic [15:0] result_nxt;

    assign bit_base = {idx, 2'b00};
    assign last_nib = byte_q ? (idx == 2'd1) : (idx == 2'd3);

    // The nibble adder answers in the same cycle, so its operands come
    // straight from the latched operands and the current index.
    assign nib_a  = (state == RUN) ? src_q[bit_base +: 4] : 4'h0;
    assign nib_b  = (state == RUN) ? dst_q[bit_base +: 4] : 4'h0;
    assign nib_ci = (state == RUN) & carry_q;

    always_comb begin
        result_nxt = result;
        result_nxt[bit_base +: 4] = nib_sum;
    end

    // Abort has priority over everything, including a start in IDLE.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            src_q   <= 16'h0000;
            dst_q   <= 16'h0000;
            byte_q  <= 1'b0;
            carry_q <= 1'b0;
            idx     <= 2'd0;
            result  <= 16'h0000;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            idx   <= 2'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q   <= op_src;
                        dst_q   <= op_dst;
                        byte_q  <= byte_mode;
                        carry_q <= carry_in;
                        idx     <= 2'd0;
                        result  <= 16'h0000;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result  <= result_nxt;
                    carry_q <= nib_co;
                    if (last_nib) begin
                        flag_c <= nib_co;
                        flag_z <= byte_q ? (result_nxt[7:0] == 8'h00)
                                         : (result_nxt == 16'h0000);
                        flag_n <= byte_q ? result_nxt[7] : result_nxt[15];
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= 2'd0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/omsp_dadd_seq.md
OMSP_DADD_SEQ -- requirements
Module: omsp_dadd_seq

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset, listed first: mclk in 1 (rising-edge clock); reset_n in 1 (async active-low reset).
REQ-002 SHALL have the following ports, one per line as name, direction, width, meaning:
- start  in  1  request a decimal add; accepted only in IDLE
- abort  in  1  synchronous cancel; return to IDLE with no done
- byte_mode  in  1  sampled at start; 1 = 2 nibbles, 0 = 4 nibbles
- op_src  in  16  BCD source operand, sampled at start
- op_dst  in  16  BCD destination operand, sampled at start
- carry_in  in  1  status C, sampled at start
- nib_a  out  4  source nibble to the nibble BCD adder
- nib_b  out  4  destination nibble to the nibble BCD adder
- nib_ci  out  1  decimal carry into the nibble adder
- nib_sum  in  4  corrected BCD digit returned by the nibble adder (combinational, same cycle)
- nib_co  in  1  decimal carry returned by the nibble adder
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result and flags valid
- result  out  16  BCD result
- flag_c  out  1  final decimal carry
- flag_z  out  1  result is zero within the operand width
- flag_n  out  1  result MSB (bit 7 in byte mode, bit 15 in word mode)

Function
REQ-003 SHALL implement states IDLE, RUN and DONE.
REQ-004 In IDLE with start=1 and abort=0, SHALL latch op_src, op_dst, carry_in and byte_mode, clear the nibble index to 0, and enter RUN.
REQ-005 In RUN, SHALL drive nib_a = op_src[4i+3:4i], nib_b = op_dst[4i+3:4i] and nib_ci = the internal carry register, where i is the nibble index.
REQ-006 In each RUN cycle, SHALL capture nib_sum into result[4i+3:4i] and nib_co into the carry register, then increment i.
REQ-007 The carry register SHALL be initialised to the latched carry_in.
REQ-008 SHALL leave RUN for DONE after the cycle with i = 1 (byte mode) or i = 3 (word mode); the index SHALL never exceed 3.
REQ-009 In DONE, SHALL assert done for exactly one cycle, then return to IDLE.
REQ-010 Timing: with start sampled at edge T, done SHALL be high in the cycle after edge T+N, where N = 2 (byte) or 4 (word), and SHALL fall at edge T+N+1.
REQ-011 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-012 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-013 Byte mode SHALL force result[15:8] = 0.
REQ-014 Flags SHALL update on entry to DONE and hold until the next accepted start:
- flag_c = carry register after the last nibble
- flag_z = (result within width == 0)
- flag_n = result MSB within width
REQ-015 result and flags SHALL hold their last values in IDLE; result SHALL be cleared to 0 on an accepted start.
REQ-016 nib_a, nib_b and nib_ci SHALL be 0 outside RUN.
REQ-017 abort=1 in any state SHALL force IDLE at the next edge with no done pulse; result and flags SHALL keep their partial/previous values.
REQ-018 abort and start asserted in the same IDLE cycle: abort SHALL win and the start SHALL be discarded.
REQ-019 Non-BCD operand digits SHALL be passed through unchecked; correction is the nibble adder's responsibility.

Reset
REQ-020 reset_n=0 SHALL asynchronously force IDLE and set result, flag_c, flag_z, flag_n, busy, done, nib_a, nib_b, nib_ci and the nibble index to 0.
REQ-021 Reset asserted mid-operation SHALL abandon the operation; no done pulse SHALL follow the reset release.
REQ-022 After reset_n deasserts, the first start SHALL be accepted at the first rising edge of mclk.

Verification
Bench models the nibble adder as: s = a+b+ci; if s>9 then digit = s+6 mod 16 with carry 1, else digit = s with carry 0.
REQ-023 Word mode, 0x1234 + 0x5678, cin=0 -> result 0x6912, C=0, Z=0, N=0; done in the cycle after T+4.
REQ-024 Word mode, 0x9999 + 0x0001, cin=0 -> result 0x0000, C=1, Z=1, N=0.
REQ-025 Byte mode, 0x45 + 0x55, cin=1 -> result 0x0001, C=1, Z=0, N=0; done in the cycle after T+2; bits 15:8 = 0.
REQ-026 Word mode, 0x4000 + 0x4000 -> result 0x8000, N=1; a second start at T+1 is ignored, and exactly one done pulse occurs.
REQ-027 abort at T+2 during a word operation -> IDLE at T+3 with no done; a subsequent 0x0001 + 0x0001 -> result 0x0002.
REQ-028 reset_n pulsed low mid-RUN -> all outputs 0 immediately, and no done pulse follows.
